// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: control bundle layout and
// steering selects used by the skid stage.
package pipe_pkg;

    localparam int unsigned WB_W       = 2;
    localparam int unsigned M_W        = 2;
    localparam int unsigned EX_W       = 4;

    // Control bundle is packed {WB, M, EX} with EX in the LSBs.
    localparam int unsigned EX_LSB     = 0;
    localparam int unsigned M_LSB      = EX_LSB + EX_W;
    localparam int unsigned WB_LSB     = M_LSB + M_W;

    localparam int unsigned CTRL_W_DEF = WB_W + M_W + EX_W;
    localparam int unsigned DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_FROM_SKID,
        MAIN_FROM_IN,
        MAIN_CLEAR
    } main_sel_e;

    typedef enum logic [1:0] {
        SKID_HOLD,
        SKID_FROM_IN,
        SKID_CLEAR
    } skid_sel_e;

    function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(
        input logic [WB_W-1:0] wb,
        input logic [M_W-1:0]  m,
        input logic [EX_W-1:0] ex
    );
        return {wb, m, ex};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid + control + payload). Load wins over clear; a clear
// zeroes valid and control but leaves the payload untouched.
module pipe_slot #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready is a flop, so upstream never sees a combinational path from out_ready.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              acc;
    logic              drn;
    main_sel_e         main_sel;
    skid_sel_e         skid_sel;

    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid_d;

    logic              in_ready_q;
    logic              in_ready_d;

    assign acc = in_valid & in_ready_q;
    assign drn = main_valid & out_ready;

    // The skid slot only fills while main is held, so main is never empty with
    // the skid occupied; the older skid entry always moves ahead of new input.
    always_comb begin
        main_sel = MAIN_HOLD;
        skid_sel = SKID_HOLD;
        if (flush_i) begin
            main_sel = MAIN_CLEAR;
            skid_sel = SKID_CLEAR;
        end else if (!main_valid || drn) begin
            if (skid_valid) begin
                main_sel = MAIN_FROM_SKID;
                skid_sel = acc ? SKID_FROM_IN : SKID_CLEAR;
            end else if (acc) begin
                main_sel = MAIN_FROM_IN;
            end else begin
                main_sel = MAIN_CLEAR;
            end
        end else if (acc) begin
            skid_sel = SKID_FROM_IN;
        end
    end

    always_comb begin
        main_load   = 1'b0;
        main_clear  = 1'b0;
        main_ctrl_d = skid_ctrl;
        main_data_d = skid_data;
        case (main_sel)
            MAIN_FROM_SKID: main_load = 1'b1;
            MAIN_FROM_IN: begin
                main_load   = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end
            MAIN_CLEAR:     main_clear = 1'b1;
            default:        ;
        endcase
    end

    always_comb begin
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        skid_valid_d = skid_valid;
        case (skid_sel)
            SKID_FROM_IN: begin
                skid_load    = 1'b1;
                skid_valid_d = 1'b1;
            end
            SKID_CLEAR: begin
                skid_clear   = 1'b1;
                skid_valid_d = 1'b0;
            end
            default:      ;
        endcase
    end

    assign in_ready_d = ~skid_valid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (main_load),
        .clear_i (main_clear),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scenario bench for pipe_skid_stage: directed handshake cases plus a long random
// run, all checked against an in-order scoreboard of accepted entries.
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int CW = 8;
    localparam int DW = 128;
    localparam int EW = CW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_i;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .CTRL_W (CW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );

    // One clock: sample handshakes on the falling edge, update the scoreboard,
    // return the drained entry and its expectation, resume 1 after the rising edge.
    task automatic tick(output bit drained, output bit have,
                        output logic [EW-1:0] exp, output logic [EW-1:0] act);
        bit acc_s, drn_s;
        @(negedge clk);
        acc_s   = in_valid && in_ready;
        drn_s   = out_valid && out_ready;
        act     = {out_ctrl, out_data};
        drained = drn_s;
        have    = 1'b0;
        exp     = '0;
        if (drn_s && sb.size() > 0) begin
            exp  = sb.pop_front();
            have = 1'b1;
        end
        if (flush_i) sb.delete();
        else if (acc_s) sb.push_back({in_ctrl, in_data});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit d, h;
        logic [EW-1:0] e, a;
        reset = 1'b0; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_init: valid=%b ctrl=%h data=%h ready=%b, want 0/0/0/1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_ctrl = 8'h3C; in_data = 128'hDEAD_0001;
        tick(d, h, e, a);
        in_data = 128'hDEAD_0002;
        tick(d, h, e, a);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 128'hDEAD_0001) begin
            n_bad++;
            $display("FAIL reset_prefill: valid=%b ready=%b data=%h, want 1/0/dead0001",
                     out_valid, in_ready, out_data);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL reset_async: valid=%b ctrl=%h data=%h, want 0/0/0",
                     out_valid, out_ctrl, out_data);
        end
        sb.delete();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_stream();
        bit d, h;
        logic [EW-1:0] e, a;
        out_ready = 1'b1; flush_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_ctrl = 8'hA5; in_data = DW'(i);
            tick(d, h, e, a);
            if (d) begin
                n_cmp++;
                if (!h || a !== e) begin
                    n_bad++;
                    $display("FAIL stream_order: got %h want %h (have=%0d)", a, e, h);
                end
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_ctrl !== 8'hA5 || out_data !== DW'(i) || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_latency: i=%0d valid=%b ctrl=%h data=%h ready=%b, want 1/a5/%0d/1",
                         i, out_valid, out_ctrl, out_data, in_ready, i);
            end
        end
        in_valid = 1'b0;
        tick(d, h, e, a);
        n_cmp++;
        if (!d || !h || a !== e) begin
            n_bad++;
            $display("FAIL stream_last: drained=%0d got %h want %h", d, a, e);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            n_bad++;
            $display("FAIL stream_empty: valid=%b ctrl=%h, want 0/0", out_valid, out_ctrl);
        end
    endtask

    task automatic test_stall();
        bit d, h, acc_now;
        logic [EW-1:0] e, a;
        int ndr;
        out_ready = 1'b0; flush_i = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h11; in_data = 'h100;
        tick(d, h, e, a);
        in_ctrl = 8'h22; in_data = 'h101;
        tick(d, h, e, a);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== DW'('h100)) begin
            n_bad++;
            $display("FAIL stall_full: valid=%b ready=%b data=%h, want 1/0/100",
                     out_valid, in_ready, out_data);
        end
        in_ctrl = 8'h33; in_data = 'h102;
        repeat (2) tick(d, h, e, a);
        n_cmp++;
        if (in_ready !== 1'b0 || out_data !== DW'('h100) || out_ctrl !== 8'h11) begin
            n_bad++;
            $display("FAIL stall_hold: ready=%b ctrl=%h data=%h, want 0/11/100",
                     in_ready, out_ctrl, out_data);
        end
        out_ready = 1'b1;
        ndr = 0;
        for (int c = 0; c < 10 && ndr < 3; c++) begin
            acc_now = in_valid && in_ready;
            tick(d, h, e, a);
            if (acc_now) in_valid = 1'b0;
            if (d) begin
                ndr++;
                n_cmp++;
                if (!h || a !== e) begin
                    n_bad++;
                    $display("FAIL stall_order: got %h want %h (have=%0d)", a, e, h);
                end
            end
        end
        n_cmp++;
        if (ndr != 3 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_count: drained=%0d valid=%b, want 3/0", ndr, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        bit d, h;
        logic [EW-1:0] e, a;
        out_ready = 1'b0; flush_i = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h44; in_data = 'h200;
        tick(d, h, e, a);
        in_ctrl = 8'h55; in_data = 'h201;
        tick(d, h, e, a);
        in_ctrl = 8'h66; in_data = 'h202; flush_i = 1'b1;
        tick(d, h, e, a);
        flush_i = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || out_data !== DW'('h200)) begin
            n_bad++;
            $display("FAIL flush_full: valid=%b ctrl=%h ready=%b data=%h, want 0/0/1/200",
                     out_valid, out_ctrl, in_ready, out_data);
        end
        repeat (2) tick(d, h, e, a);
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            n_bad++;
            $display("FAIL flush_absent: valid=%b ctrl=%h, want 0/0", out_valid, out_ctrl);
        end
        // Main-only variant: entry accepted and main drained in the flush cycle.
        in_valid = 1'b1; in_ctrl = 8'h77; in_data = 'h203;
        tick(d, h, e, a);
        out_ready = 1'b1; in_ctrl = 8'h78; in_data = 'h204; flush_i = 1'b1;
        tick(d, h, e, a);
        flush_i = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (!d || !h || a !== e || a !== {8'h77, DW'('h203)}) begin
            n_bad++;
            $display("FAIL flush_drain: drained=%0d got %h want %h", d, a, e);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_drop: valid=%b ctrl=%h ready=%b, want 0/0/1",
                     out_valid, out_ctrl, in_ready);
        end
    endtask

    task automatic test_simultaneous();
        bit d, h;
        logic [EW-1:0] e, a;
        out_ready = 1'b0; flush_i = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h81; in_data = 'h300;
        tick(d, h, e, a);
        in_ctrl = 8'h82; in_data = 'h301;
        tick(d, h, e, a);
        out_ready = 1'b1; in_ctrl = 8'h83; in_data = 'h302;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_ready: ready=%b, want 0", in_ready);
        end
        tick(d, h, e, a);
        n_cmp++;
        if (!d || !h || a !== e) begin
            n_bad++;
            $display("FAIL simul_drain0: drained=%0d got %h want %h", d, a, e);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'h82 || out_data !== DW'('h301) || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_shift: valid=%b ctrl=%h data=%h ready=%b, want 1/82/301/1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        tick(d, h, e, a);
        in_valid = 1'b0;
        n_cmp++;
        if (!d || !h || a !== e || out_data !== DW'('h302)) begin
            n_bad++;
            $display("FAIL simul_next: got %h want %h, main data=%h want 302", a, e, out_data);
        end
        tick(d, h, e, a);
        n_cmp++;
        if (!d || !h || a !== e || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_last: got %h want %h valid=%b", a, e, out_valid);
        end
    endtask

    task automatic test_random();
        bit d, h;
        logic [EW-1:0] e, a;
        logic [DW-1:0] seq;
        seq = 'h1000;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush_i   = ($urandom_range(0, 99) < 3);
            in_ctrl   = pack_ctrl(WB_W'($urandom), M_W'($urandom), EX_W'($urandom));
            in_data   = seq;
            seq       = seq + 1'b1;
            tick(d, h, e, a);
            if (d) begin
                n_cmp++;
                if (!h || a !== e) begin
                    n_bad++;
                    $display("FAIL rand_order: cyc=%0d got %h want %h (have=%0d)", c, a, e, h);
                end
            end
            n_cmp++;
            if (out_valid !== (sb.size() > 0) || in_ready !== (sb.size() < 2) ||
                (!out_valid && out_ctrl !== '0)) begin
                n_bad++;
                $display("FAIL rand_state: cyc=%0d valid=%b ready=%b ctrl=%h, held=%0d",
                         c, out_valid, in_ready, out_ctrl, sb.size());
            end
        end
        in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(d, h, e, a);
            if (d) begin
                n_cmp++;
                if (!h || a !== e) begin
                    n_bad++;
                    $display("FAIL rand_drain: got %h want %h (have=%0d)", a, e, h);
                end
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL rand_final: valid=%b left=%0d, want 0/0", out_valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
